// File: rtl/memstage_pkg.sv
// Shared MEM-stage types: access sizes and the MEM/WB bundle.
// The bubble is the all-zero MEM/WB bundle.
package memstage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef struct packed {
        logic [31:0] readdata;
        logic [31:0] alu_out;
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  write_reg;
        logic        misalign;
    } mem_wb_t;

    localparam mem_wb_t BUBBLE = '0;

endpackage

// File: rtl/memstage_if.sv
// MEM-stage bus: execute-side request/control in, writeback bundle out.
// master = pipeline driving the stage, slave = memstage.
interface memstage_if;
    import memstage_pkg::*;

    logic [31:0] MEMaluOut;
    logic [31:0] MEMwriteData;
    logic        MEMmemRead;
    logic        MEMmemWrite;
    size_e       MEMsize;
    logic        MEMsigned;
    logic        MEMmemtoReg;
    logic        MEMregWrite;
    logic [4:0]  MEMwriteReg;
    logic        stall;
    logic        flush;
    logic [31:0] WBreaddata;
    logic [31:0] WBaluOut;
    logic        WBmemtoReg;
    logic        WBregWrite;
    logic [4:0]  WBwriteReg;
    logic        WBmisalign;

    modport master (
        output MEMaluOut, MEMwriteData, MEMmemRead, MEMmemWrite,
        output MEMsize, MEMsigned, MEMmemtoReg, MEMregWrite,
        output MEMwriteReg, stall, flush,
        input  WBreaddata, WBaluOut, WBmemtoReg, WBregWrite,
        input  WBwriteReg, WBmisalign
    );

    modport slave (
        input  MEMaluOut, MEMwriteData, MEMmemRead, MEMmemWrite,
        input  MEMsize, MEMsigned, MEMmemtoReg, MEMregWrite,
        input  MEMwriteReg, stall, flush,
        output WBreaddata, WBaluOut, WBmemtoReg, WBregWrite,
        output WBwriteReg, WBmisalign
    );

endinterface

// File: rtl/memstage_dmem.sv
// Word-wide data memory: combinational read, per-byte-lane write enables.
// we[3] is lane 31:24 (big-endian offset 0).
module dmem #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/memstage.sv
// MEM pipeline stage: lane select, extension, alignment check and
// the MEM/WB register in front of a byte-lane data memory.
module memstage
    import memstage_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic       clk,
    input  logic       reset,
    memstage_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   rword;
    logic [31:0]   wdata;
    logic [31:0]   lane;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [3:0]    be;
    logic          access;
    logic          mis;
    logic          commit;
    logic          unused_hi;
    mem_wb_t       wb_d;
    mem_wb_t       wb_q;

    // Upper address bits are ignored so accesses wrap modulo 4*DEPTH.
    assign idx       = bus.MEMaluOut[AW+1:2];
    assign off       = bus.MEMaluOut[1:0];
    assign unused_hi = ^bus.MEMaluOut[31:AW+2];
    assign access    = bus.MEMmemRead | bus.MEMmemWrite;
    assign rbyte     = 8'(rword >> {~off, 3'b000});
    assign rhalf     = off[1] ? rword[15:0] : rword[31:16];

    always_comb begin
        be    = 4'b1111;
        wdata = bus.MEMwriteData;
        lane  = rword;
        mis   = 1'b0;
        unique case (bus.MEMsize)
            SZ_BYTE: begin
                be    = 4'b1000 >> off;
                wdata = {4{bus.MEMwriteData[7:0]}};
                lane  = {{24{bus.MEMsigned & rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                be    = off[1] ? 4'b0011 : 4'b1100;
                wdata = {2{bus.MEMwriteData[15:0]}};
                lane  = {{16{bus.MEMsigned & rhalf[15]}}, rhalf};
                mis   = access & off[0];
            end
            SZ_WORD, SZ_RSVD: begin
                mis   = access & (off != 2'b00);
            end
        endcase
    end

    assign commit = bus.MEMmemWrite & ~mis & ~bus.stall
                  & ~bus.flush & ~reset;

    dmem #(.DEPTH(DEPTH)) u_dmem (
        .clk   (clk),
        .addr  (idx),
        .we    (commit ? be : 4'b0000),
        .wdata (wdata),
        .rdata (rword)
    );

    always_comb begin
        wb_d = wb_q;
        if (bus.flush) begin
            wb_d = BUBBLE;
        end else if (!bus.stall) begin
            wb_d.readdata   = (bus.MEMmemRead & ~mis) ? lane : 32'd0;
            wb_d.alu_out    = bus.MEMaluOut;
            wb_d.mem_to_reg = bus.MEMmemtoReg;
            wb_d.reg_write  = bus.MEMregWrite & ~mis;
            wb_d.write_reg  = bus.MEMwriteReg;
            wb_d.misalign   = mis;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) wb_q <= BUBBLE;
        else       wb_q <= wb_d;
    end

    assign bus.WBreaddata = wb_q.readdata;
    assign bus.WBaluOut   = wb_q.alu_out;
    assign bus.WBmemtoReg = wb_q.mem_to_reg;
    assign bus.WBregWrite = wb_q.reg_write;
    assign bus.WBwriteReg = wb_q.write_reg;
    assign bus.WBmisalign = wb_q.misalign;

endmodule

// File: doc/memstage.md
MEMSTAGE -- requirements
Module: memstage

Interface
REQ-001 Parameter: DEPTH, 256, data-memory depth in 32-bit words (power of two).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MEMaluOut  input  32  byte address from execute stage; also forwarded as ALU result.
REQ-005 MEMwriteData  input  32  store data (rt value).
REQ-006 MEMmemRead  input  1  load request.
REQ-007 MEMmemWrite  input  1  store request.
REQ-008 MEMsize  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-009 MEMsigned  input  1  1 = sign-extend byte/half loads, 0 = zero-extend.
REQ-010 MEMmemtoReg, MEMregWrite  input  1 each  control passed to writeback.
REQ-011 MEMwriteReg  input  5  destination register number.
REQ-012 stall  input  1  hold MEM/WB register and suppress store.
REQ-013 flush  input  1  replace MEM instruction with bubble.
REQ-014 WBreaddata, WBaluOut  output  32 each  registered load data and ALU result to writeback.
REQ-015 WBmemtoReg, WBregWrite  output  1 each  registered control.
REQ-016 WBwriteReg  output  5  registered destination register.
REQ-017 WBmisalign  output  1  registered misaligned-access flag.

Function
REQ-018 Word index is MEMaluOut[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-019 Memory read is combinational; write occurs on the clock edge; a load and a store to the same word in the same cycle return the old word.
REQ-020 Byte lanes are big-endian: offset 0 -> bits 31:24, offset 3 -> bits 7:0; half offset 0 -> bits 31:16, offset 2 -> bits 15:0.
REQ-021 Byte/half loads extract the addressed lane and extend to 32 bits per MEMsigned; word loads pass the word unchanged.
REQ-022 Byte/half stores modify only the addressed lane(s) using the low bits of MEMwriteData; other lanes remain unchanged.
REQ-023 Misaligned: half with MEMaluOut[0]=1, or word with MEMaluOut[1:0]!=00, when MEMmemRead or MEMmemWrite is 1.
REQ-024 On misaligned access: store suppressed, WBreaddata=0, WBregWrite=0, WBmisalign=1; other fields are registered normally.
REQ-025 A store commits only when MEMmemWrite=1, aligned, stall=0, flush=0, reset=0.
REQ-026 WBreaddata is 0 when MEMmemRead=0.
REQ-027 Latency: inputs presented in cycle N appear on WB outputs after edge N+1 (one pipeline register).
REQ-028 Priority on each edge: reset > flush > stall > normal load.
REQ-029 flush=1: WB register loads bubble (all outputs 0) regardless of stall.
REQ-030 stall=1 (flush=0): all WB outputs hold their previous values.
REQ-031 MEMmemRead and MEMmemWrite both 1: store performed per REQ-025, load returns pre-store word.

Reset
REQ-032 reset=1 on an edge clears every WB output to 0 and suppresses any store in that cycle.
REQ-033 Memory contents are not cleared by reset; contents before the first store are undefined.
REQ-034 Reset asserted mid-stall or mid-flush overrides both; normal operation resumes on the first edge with reset=0.

Structure
REQ-035 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the bubble value belong in the shared pipeline package.
REQ-036 Data memory array with byte-lane write enables is a sub-module named dmem; lane select, extension, alignment check and MEM/WB register stay in memstage.

Verification
REQ-037 Store word 0xDEADBEEF at 0x10, then load word 0x10 signed -> WBreaddata=0xDEADBEEF one cycle after load presented.
REQ-038 After REQ-037: load byte 0x11 signed -> 0xFFFFFFAD; unsigned -> 0x000000AD; load half 0x12 signed -> 0xFFFFBEEF.
REQ-039 Store byte 0x55 at 0x13, load word 0x10 -> 0xDEADBE55; store word at 0x12 -> WBmisalign=1, WBregWrite=0, memory unchanged.
REQ-040 Stall for 3 cycles with store to 0x20 presented -> WB outputs frozen, word 0x20 unchanged; release -> store commits once.
REQ-041 flush and stall together with MEMregWrite=1 -> all WB outputs 0 next cycle; reset asserted mid-stream -> all WB outputs 0, pending store dropped.
REQ-042 DEPTH=256: store to 0x400 then load 0x000 -> same word returned (wrap-around).
